mips_alu: RTL and testbench
===========================

// Module: mips_alu
// PURPOSE
//  Registered 16-function integer ALU for the MIPS datapath (execute stage).
//  Computes arithmetic, logic and shift results plus carry/borrow, equality and zero flags.
//  Operands and opcode are sampled each clock; result and flags are registered, latency 1.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width in bits (power of 2, >=8)
// PORTS
//  clk      in   1            system clock, rising-edge active
//  rst      in   1            asynchronous reset, active-high
//  rega     in   DATA_WIDTH   operand A
//  regb     in   DATA_WIDTH   operand B / shift amount
//  control  in   4            opcode, see table
//  out_alu  out  DATA_WIDTH   registered result
//  cout     out  1            registered carry (ADD, SOME) / borrow (SUB)
//  equal    out  1            registered (rega == regb)
//  zero     out  1            registered (next out_alu == 0)
// BEHAVIOUR
//  - Reset: async assert forces out_alu=0, cout=0, equal=0, zero=0; held while rst=1.
//  - Each rising clk with rst=0: all four outputs load from combinational function of current inputs.
//    Latency exactly 1 cycle; no handshake, no enable; new op accepted every cycle.
//  - SH = low log2(DATA_WIDTH) bits of regb (5 bits at 32); upper regb bits ignored for shifts.
//  - Opcode table (A=rega, B=regb, all modulo 2^DATA_WIDTH):
//     0 ADD  A+B;          cout = carry out of MSB
//     1 SUB  A-B;          cout = borrow = (A < B unsigned)
//     2 AND  A&B    3 OR  A|B    4 XOR  A^B
//     5 L_SH A << SH (zero fill)
//     6 R_SH A >> SH (logical, zero fill)
//     7 NAND ~(A&B) 8 NOR ~(A|B) 9 XNOR ~(A^B)
//    10 NOT  ~A (B ignored)
//    11 COMP result = {0..0, A==B}
//    12 SRA  A >>> SH (sign bit A[MSB] replicated)
//    13 SUBO A-1 (B ignored); 0 wraps to all-ones
//    14 SIG  -A two's complement (B ignored); -0 = 0, -MIN = MIN
//    15 SOME A + ~B (= A-B-1); cout = carry out of MSB
//  - cout = 0 for every opcode other than ADD, SUB, SOME.
//  - equal computed for every opcode, independent of control.
//  - zero reflects the result loaded in the same edge, every opcode.
//  - No overflow flag; signed/unsigned wrap identical for ADD/SUB.
//  - Shift by SH=0 returns A unchanged; SH=DATA_WIDTH-1 is the maximal shift.
//  - Reset mid-operation discards the pending result; first post-reset edge computes from live inputs.
// TESTING (sample outputs one edge after applying inputs, DATA_WIDTH=32)
//  - Reset: rst=1 async, no clock -> out_alu=0, cout=0, equal=0, zero=0 immediately.
//  - Arith: ADD 10,20 -> 30; SUB 50,20 -> 30; ADD FFFFFFFF,1 -> 0, cout=1, zero=1;
//    SUB 0,1 -> FFFFFFFF, cout=1; SUB 10,10 -> 0, zero=1.
//  - Logic: AND 00FF,0F0F -> 000F; OR -> 0FFF; XOR AAAA5555,FFFF0000 -> 55555555;
//    NOR FF00FF00,00FF00FF -> 0; NOT 0 -> FFFFFFFF; NOT FFFFFFFF -> 0.
//  - Shifts: L_SH 1,33 -> 2; R_SH 2,33 -> 1; SRA 80000000,1 -> C0000000.
//  - Misc: COMP 100,100 -> equal=1, out=1; COMP 100,101 -> equal=0; SUBO 5 -> 4;
//    SIG 5 -> FFFFFFFB; SOME 7,2 -> 4.
//  - Back-to-back: change opcode every cycle across all 16 -> each result appears exactly one edge later.

Source files
------------

// File: rtl/mips_alu.sv
// Registered 16-function integer ALU for the execute stage.
// Result and flags (carry/borrow, equality, zero) load every clock, latency 1.
module mips_alu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rega,
   input  logic [DATA_WIDTH-1:0] regb,
   input  logic [3:0]            control,
   output logic [DATA_WIDTH-1:0] out_alu,
   output logic                  cout,
   output logic                  equal,
   output logic                  zero
);

   localparam int SH_W = $clog2(DATA_WIDTH);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_LSH  = 4'd5,
      OP_RSH  = 4'd6,
      OP_NAND = 4'd7,
      OP_NOR  = 4'd8,
      OP_XNOR = 4'd9,
      OP_NOT  = 4'd10,
      OP_COMP = 4'd11,
      OP_SRA  = 4'd12,
      OP_SUBO = 4'd13,
      OP_SIG  = 4'd14,
      OP_SOME = 4'd15
   } alu_op_t;

   logic [SH_W-1:0]       sh;
   logic [DATA_WIDTH:0]   sum_add;
   logic [DATA_WIDTH:0]   sum_some;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] res_next;
   logic                  cout_next;
   logic                  eq_next;

   // Upper regb bits are deliberately ignored for shift amounts.
   assign sh       = regb[SH_W-1:0];
   assign sum_add  = {1'b0, rega} + {1'b0, regb};
   assign sum_some = {1'b0, rega} + {1'b0, ~regb};
   assign diff     = rega - regb;
   assign eq_next  = (rega == regb);

   // Combinational function select; carry only meaningful for ADD, SUB and SOME.
   always_comb begin
      res_next  = '0;
      cout_next = 1'b0;
      case (alu_op_t'(control))
         OP_ADD: begin
            res_next  = sum_add[DATA_WIDTH-1:0];
            cout_next = sum_add[DATA_WIDTH];
         end
         OP_SUB: begin
            res_next  = diff;
            cout_next = (rega < regb);
         end
         OP_AND:  res_next = rega & regb;
         OP_OR:   res_next = rega | regb;
         OP_XOR:  res_next = rega ^ regb;
         OP_LSH:  res_next = rega << sh;
         OP_RSH:  res_next = rega >> sh;
         OP_NAND: res_next = ~(rega & regb);
         OP_NOR:  res_next = ~(rega | regb);
         OP_XNOR: res_next = ~(rega ^ regb);
         OP_NOT:  res_next = ~rega;
         OP_COMP: res_next = {{(DATA_WIDTH-1){1'b0}}, eq_next};
         OP_SRA:  res_next = $unsigned($signed(rega) >>> sh);
         OP_SUBO: res_next = rega - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
         OP_SIG:  res_next = '0 - rega;
         OP_SOME: begin
            res_next  = sum_some[DATA_WIDTH-1:0];
            cout_next = sum_some[DATA_WIDTH];
         end
         default: res_next = '0;
      endcase
   end

   // Output register: all four outputs load together every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_alu <= '0;
         cout    <= 1'b0;
         equal   <= 1'b0;
         zero    <= 1'b0;
      end else begin
         out_alu <= res_next;
         cout    <= cout_next;
         equal   <= eq_next;
         zero    <= (res_next == '0);
      end
   end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases, reset behaviour and
// randomized back-to-back traffic against an arithmetic reference model.
module tb_mips_alu;

   logic        clk;
   logic        rst;
   logic [31:0] rega;
   logic [31:0] regb;
   logic [3:0]  control;
   logic [31:0] out_alu;
   logic        cout;
   logic        equal;
   logic        zero;

   int n_checks = 0;
   int n_errors = 0;

   mips_alu #(.DATA_WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .rega    (rega),
      .regb    (regb),
      .control (control),
      .out_alu (out_alu),
      .cout    (cout),
      .equal   (equal),
      .zero    (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
      end
   endtask

   // Reference model written from the opcode rules using 64-bit arithmetic.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic c);
      longint unsigned au, bu, s;
      int unsigned     shamt;
      au    = 64'(a);
      bu    = 64'(b);
      shamt = b % 32;
      c     = 1'b0;
      case (op)
         4'd0:  begin s = au + bu; r = s[31:0]; c = s[32]; end
         4'd1:  begin r = 32'(au - bu); c = (au < bu); end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = 32'(au * (64'd1 << shamt));
         4'd6:  r = 32'(au / (64'd1 << shamt));
         4'd7:  r = ~(a & b);
         4'd8:  r = ~(a | b);
         4'd9:  r = ~(a ^ b);
         4'd10: r = ~a;
         4'd11: r = (a == b) ? 32'd1 : 32'd0;
         4'd12: begin
            // Floor division of the signed value by 2^shamt.
            longint sa, q;
            sa = longint'($signed(a));
            q  = sa / (64'sd1 <<< shamt);
            if ((sa < 0) && (q * (64'sd1 <<< shamt) != sa)) q = q - 1;
            r = 32'(q);
         end
         4'd13: r = 32'(au + 64'hFFFF_FFFF);
         4'd14: r = 32'(64'h1_0000_0000 - au);
         default: begin s = au + (64'hFFFF_FFFF - bu); r = s[31:0]; c = s[32]; end
      endcase
   endtask

   // Apply one operation, let one edge pass, compare all outputs with the model.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r_exp;
      logic        c_exp;
      logic [31:0] prev;
      prev    = out_alu;
      rega    = a;
      regb    = b;
      control = op;
      model(op, a, b, r_exp, c_exp);
      #2;
      check({tag, ".hold"}, out_alu, prev);
      @(posedge clk);
      #1;
      check({tag, ".out"},   out_alu, r_exp);
      check({tag, ".cout"},  32'(cout),  32'(c_exp));
      check({tag, ".equal"}, 32'(equal), 32'(a == b));
      check({tag, ".zero"},  32'(zero),  32'(r_exp == 32'd0));
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      rst     = 1'b1;
      rega    = 32'd0;
      regb    = 32'd0;
      control = 4'd0;
      #1;
      check("rst.out",   out_alu, 32'd0);
      check("rst.flags", {29'd0, cout, equal, zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("add",      4'd0,  32'd10, 32'd20);
      run_op("sub",      4'd1,  32'd50, 32'd20);
      run_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd1);
      run_op("sub_brw",  4'd1,  32'd0, 32'd1);
      run_op("sub_zero", 4'd1,  32'd10, 32'd10);
      run_op("and",      4'd2,  32'h0000_00FF, 32'h0000_0F0F);
      run_op("or",       4'd3,  32'h0000_00FF, 32'h0000_0F0F);
      run_op("xor",      4'd4,  32'hAAAA_5555, 32'hFFFF_0000);
      run_op("nor",      4'd8,  32'hFF00_FF00, 32'h00FF_00FF);
      run_op("not0",     4'd10, 32'd0, 32'h1234_5678);
      run_op("not1",     4'd10, 32'hFFFF_FFFF, 32'd0);
      run_op("lsh33",    4'd5,  32'd1, 32'd33);
      run_op("rsh33",    4'd6,  32'd2, 32'd33);
      run_op("sra1",     4'd12, 32'h8000_0000, 32'd1);
      run_op("sra31",    4'd12, 32'h8000_0000, 32'd31);
      run_op("lsh0",     4'd5,  32'hDEAD_BEEF, 32'd0);
      run_op("lsh31",    4'd5,  32'h0000_0003, 32'd31);
      run_op("comp_eq",  4'd11, 32'd100, 32'd100);
      run_op("comp_ne",  4'd11, 32'd100, 32'd101);
      run_op("subo",     4'd13, 32'd5, 32'd77);
      run_op("subo0",    4'd13, 32'd0, 32'd0);
      run_op("sig",      4'd14, 32'd5, 32'd9);
      run_op("sig_min",  4'd14, 32'h8000_0000, 32'd0);
      run_op("some",     4'd15, 32'd7, 32'd2);
      run_op("some_eq",  4'd15, 32'd7, 32'd7);
      run_op("nand",     4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00);
      run_op("xnor",     4'd9,  32'hF0F0_F0F0, 32'hFF00_FF00);

      // Asynchronous reset mid-stream clears immediately, then live inputs are used.
      #2;
      rst = 1'b1;
      #1;
      check("arst.out",   out_alu, 32'd0);
      check("arst.flags", {29'd0, cout, equal, zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", 4'd1, 32'd9, 32'd4);

      // Back-to-back sweep over every opcode, then random traffic.
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op("sweep", 4'(i), ra, rb);
      end
      for (int i = 0; i < 300; i++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
         if ($urandom_range(0, 9) == 0) ra = 32'hFFFF_FFFF;
         rop = 4'($urandom_range(0, 15));
         run_op("rand", rop, ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
